uart_tx: RTL and testbench

Serial transmitter that consumes the status bytes produced by the manoeuvre FSMs (turn left/right, line follow, done) and sends them as 8N1 UART frames to the robot's telemetry link. It accepts one byte at a time over a valid/ready handshake and holds it in a one-entry buffer. This lets the next byte be accepted while the current frame is still shifting out, so frames go back-to-back without an idle gap.

---
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx -- 8N1 UART transmitter for the manoeuvre-FSM status telemetry link.
//
// A one-entry holding buffer sits in front of the shift register. The next
// byte can be accepted while the current frame is still shifting out, so
// frames leave back-to-back with no idle bit between them.
//
// Ports
//   clk       in   system clock (100 MHz)
//   reset     in   synchronous, active-high reset
//   tx_data   in   [7:0] byte to send, sampled only on an accept edge
//   tx_valid  in   upstream has a byte on tx_data
//   tx_ready  out  holding buffer empty; accept = tx_valid & tx_ready at posedge
//   tx        out  serial line, idle high, LSB first
//   busy      out  frame in flight or holding buffer occupied
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int DATA_W = 8;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     baud;
    logic [2:0]        bit_idx;
    logic              accept;
    logic              bit_end;

    assign tx_ready = ~hold_full;
    assign busy     = (state != IDLE) | hold_full;
    assign accept   = tx_valid & ~hold_full;
    assign bit_end  = (baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            hold_full <= 1'b0;
            baud      <= '0;
            bit_idx   <= '0;
        end else begin
            // Accept needs hold_full=0 and a load needs hold_full=1, so the
            // two never touch hold_full on the same edge.
            if (accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (hold_full) begin
                        sh        <= hold_data;
                        hold_full <= 1'b0;
                        baud      <= '0;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= sh[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // sh[1] becomes sh[0] after the shift below.
                            sh      <= sh >> 1;
                            tx      <= sh[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (hold_full) begin
                            // Chain straight into the next start bit.
                            sh        <= hold_data;
                            hold_full <= 1'b0;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx -- directed bench for uart_tx: one instance with CLKS_PER_BIT=4
// for the framing/handshake cases and one with the default 868.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;

    uart_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data_a),
        .tx_valid (tx_valid_a),
        .tx_ready (tx_ready_a),
        .tx       (tx_a),
        .busy     (busy_a)
    );

    uart_tx dut_b (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data_b),
        .tx_valid (tx_valid_b),
        .tx_ready (tx_ready_b),
        .tx       (tx_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one frame cycle by cycle starting at offset 'start' from the edge
    // where tx fell; leaves time just after the edge that ends the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b, input int cpb,
                               input bit sel, input int start, input logic exp_rdy);
        logic [9:0] fr;
        logic [7:0] dec;
        logic       t;
        int         j;
        fr  = {1'b1, b, 1'b0};
        dec = 8'h00;
        for (int i = start; i < 10 * cpb; i++) begin
            j = i / cpb;
            t = sel ? tx_b : tx_a;
            check({tag, "_tx"}, {7'd0, t}, {7'd0, fr[j]});
            check({tag, "_busy"}, {7'd0, sel ? busy_b : busy_a}, 8'd1);
            check({tag, "_rdy"}, {7'd0, sel ? tx_ready_b : tx_ready_a}, {7'd0, exp_rdy});
            if ((i % cpb) == (cpb / 2) && j >= 1 && j <= 8) dec[j-1] = t;
            tick(1);
        end
        check({tag, "_dec"}, dec, b);
    endtask

    initial begin
        reset      = 1'b1;
        tx_data_a  = 8'h99;
        tx_valid_a = 1'b1;
        tx_data_b  = 8'h00;
        tx_valid_b = 1'b0;

        // Reset state, with a byte offered during reset
        tick(2);
        check("rst_tx",   {7'd0, tx_a}, 8'd1);
        check("rst_rdy",  {7'd0, tx_ready_a}, 8'd1);
        check("rst_busy", {7'd0, busy_a}, 8'd0);
        check("rst_tx_b", {7'd0, tx_b}, 8'd1);
        reset      = 1'b0;
        tx_valid_a = 1'b0;
        tick(3);
        check("rst_noacc_busy", {7'd0, busy_a}, 8'd0);
        check("rst_noacc_tx",   {7'd0, tx_a}, 8'd1);

        // Single byte 'D'
        tx_data_a  = 8'h44;
        tx_valid_a = 1'b1;
        check("d_rdy_pre", {7'd0, tx_ready_a}, 8'd1);
        tick(1);
        tx_valid_a = 1'b0;
        check("d_rdy_acc",  {7'd0, tx_ready_a}, 8'd0);
        check("d_busy_acc", {7'd0, busy_a}, 8'd1);
        check("d_tx_acc",   {7'd0, tx_a}, 8'd1);
        tick(1);
        check_frame("d", 8'h44, 4, 1'b0, 0, 1'b1);
        check("d_busy_end", {7'd0, busy_a}, 8'd0);
        check("d_tx_end",   {7'd0, tx_a}, 8'd1);
        tick(2);

        // Back-to-back 0x44 then 0x00 with tx_valid held high
        tx_data_a  = 8'h44;
        tx_valid_a = 1'b1;
        tick(1);
        tx_data_a = 8'h00;
        check("b2b_rdy_acc1", {7'd0, tx_ready_a}, 8'd0);
        tick(1);
        check("b2b_tx_load1", {7'd0, tx_a}, 8'd0);
        check("b2b_rdy_load1", {7'd0, tx_ready_a}, 8'd1);
        tick(1);
        tx_valid_a = 1'b0;
        check_frame("b2b1", 8'h44, 4, 1'b0, 1, 1'b0);
        check_frame("b2b2", 8'h00, 4, 1'b0, 0, 1'b1);
        check("b2b_busy_end", {7'd0, busy_a}, 8'd0);
        tick(2);

        // Buffer full: 0x55, 0xAA, then 0x0F offered while the buffer holds 0xAA
        tx_data_a  = 8'h55;
        tx_valid_a = 1'b1;
        tick(1);
        tx_data_a = 8'hAA;
        tick(1);
        tick(1);
        tx_data_a = 8'h0F;
        check("full_rdy", {7'd0, tx_ready_a}, 8'd0);
        check_frame("f55", 8'h55, 4, 1'b0, 1, 1'b0);
        check("fAA_tx0",  {7'd0, tx_a}, 8'd0);
        check("fAA_rdy0", {7'd0, tx_ready_a}, 8'd1);
        tick(1);
        tx_valid_a = 1'b0;
        check_frame("fAA", 8'hAA, 4, 1'b0, 1, 1'b0);
        check_frame("f0F", 8'h0F, 4, 1'b0, 0, 1'b1);
        check("full_busy_end", {7'd0, busy_a}, 8'd0);
        tick(2);

        // Reset during data bit 3 of 0x35 with 0xC3 pending
        tx_data_a  = 8'h35;
        tx_valid_a = 1'b1;
        tick(1);
        tx_data_a = 8'hC3;
        tick(1);
        tick(1);
        tx_valid_a = 1'b0;
        tick(16);
        check("mid_tx_bit3", {7'd0, tx_a}, 8'd0);
        check("mid_rdy_pend", {7'd0, tx_ready_a}, 8'd0);
        reset = 1'b1;
        tick(1);
        check("mid_rst_tx",   {7'd0, tx_a}, 8'd1);
        check("mid_rst_rdy",  {7'd0, tx_ready_a}, 8'd1);
        check("mid_rst_busy", {7'd0, busy_a}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            check("mid_quiet_tx",   {7'd0, tx_a}, 8'd1);
            check("mid_quiet_busy", {7'd0, busy_a}, 8'd0);
            tick(1);
        end

        // Default CLKS_PER_BIT=868, byte 0x41
        tx_data_b  = 8'h41;
        tx_valid_b = 1'b1;
        tick(1);
        tx_valid_b = 1'b0;
        check("def_rdy_acc", {7'd0, tx_ready_b}, 8'd0);
        check("def_tx_acc",  {7'd0, tx_b}, 8'd1);
        tick(1);
        check_frame("def", 8'h41, 868, 1'b1, 0, 1'b1);
        check("def_busy_end", {7'd0, busy_b}, 8'd0);
        check("def_tx_end",   {7'd0, tx_b}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
